alu_mdu: RTL and testbench
==========================

ALU_MDU -- requirements
Module: alu_mdu

Interface
REQ-001 Parameter XLEN, default 32, operand/result width; legal values 8..64, power of two.
REQ-002 Parameter CTRL_BITS, default 5, width of op field.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 req_valid  input  1  request present.
REQ-006 req_ready  output  1  block can accept a request.
REQ-007 op  input  CTRL_BITS  operation, ALUCTRL_* encoding plus M-extension codes.
REQ-008 rs1, rs2, imm  input  XLEN each  operand 1, register operand 2, immediate.
REQ-009 alu_src  input  1  0 selects rs2, 1 selects imm, as operand 2.
REQ-010 kill  input  1  abort current operation; no response produced.
REQ-011 resp_valid  output  1  result/taken valid.
REQ-012 resp_ready  input  1  consumer accepts response.
REQ-013 result  output  XLEN  operation result.
REQ-014 taken  output  1  branch condition true (branch ops only, else 0).
REQ-015 busy  output  1  high in CALC state.

Function
REQ-016 Transfer on req_valid && req_ready; operands, op and alu_src latched in that cycle; later input changes ignored.
REQ-017 FSM states IDLE, CALC, DONE; req_ready = 1 only in IDLE; no request overlap.
REQ-018 Single-cycle ops (ADD, SUB, AND, OR, XOR, SLL, SRL, SRA, SLT, SLTU, BEQ, BNE, BLT, BGE, BLTU, BGEU): IDLE -> DONE, resp_valid high exactly 1 cycle after acceptance.
REQ-019 Multi-cycle ops (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU): IDLE -> CALC for exactly XLEN cycles, iteration counter 0..XLEN-1, then DONE; resp_valid high XLEN+1 cycles after acceptance.
REQ-020 DONE: resp_valid, result, taken held stable until resp_ready; DONE -> IDLE on resp_ready; next request acceptable the following cycle.
REQ-021 Arithmetic modulo 2^XLEN; SUB = rs1 - op2 via two's complement; no overflow flag.
REQ-022 Shifts use op2[log2(XLEN)-1:0] only; SRA sign-fills.
REQ-023 SLT/SLTU result = zero-extended 1/0; signed vs unsigned compare per op.
REQ-024 Branch ops: taken = eq/ne/lt/ge/ltu/geu of rs1 vs op2; result = 0.
REQ-025 MUL returns low XLEN bits; MULH/MULHSU/MULHU high XLEN bits of signed*signed, signed*unsigned, unsigned*unsigned 2*XLEN product.
REQ-026 Divide by zero: quotient all-ones, remainder = rs1; latency unchanged.
REQ-027 Signed overflow (rs1 = most negative, op2 = -1): DIV = rs1, REM = 0; latency unchanged.
REQ-028 Quotient rounds toward zero; remainder sign follows dividend.
REQ-029 Undefined op: result 0, taken 0, single-cycle path.
REQ-030 kill in any state: FSM -> IDLE next cycle, resp_valid 0 next cycle, pending result discarded; kill has priority over request acceptance and resp_ready in the same cycle.

Reset
REQ-031 rst_n low at a rising edge: FSM -> IDLE, counter 0, resp_valid 0, result 0, taken 0, busy 0; req_ready 1 from first cycle after reset release.
REQ-032 Reset mid-CALC or mid-DONE discards the operation; no response emitted afterwards.

Structure
REQ-033 Opcode encodings (existing ALUCTRL_* plus new MUL..REMU codes) and default XLEN/CTRL_BITS live in the shared ALU control definitions package; no literal opcodes in the module.
REQ-034 Iterative shift-add multiplier / restoring divider in one sub-module alu_mdu_seq (start, sign controls, operands in; done, product/quotient/remainder out); single-cycle datapath stays in alu_mdu.

Verification (XLEN=32)
REQ-035 ADD rs1=0xFFFFFFFF, rs2=1, alu_src=0 -> resp_valid 1 cycle later, result 0x00000000, taken 0.
REQ-036 BLT rs1=0xFFFFFFFE, rs2=1 -> taken 1; BLTU same operands -> taken 0; both result 0.
REQ-037 MULH rs1=0x80000000, rs2=0x80000000 -> resp_valid 33 cycles after acceptance, result 0x40000000; busy high cycles 1..32.
REQ-038 DIV rs1=7, rs2=0 -> result 0xFFFFFFFF; REM same -> 7; DIV 0x80000000 by 0xFFFFFFFF -> 0x80000000; DIVU 0xFFFFFFF9 by 2 -> 0x7FFFFFFC.
REQ-039 DIVU started, kill at CALC cycle 10 -> resp_valid never asserts, req_ready 1 next cycle, subsequent SUB 5-7 -> 0xFFFFFFFE.
REQ-040 resp_ready held low 5 cycles in DONE -> result stable, req_ready 0 throughout; rst_n low during CALC -> all outputs at reset values next cycle.

Source files
------------

// File: rtl/alu_mdu_pkg.sv
// ALU control definitions shared by the ALU/MDU datapath, its interface and bench.
// Opcode encodings, default widths and FSM/select enums live here.
package alu_mdu_pkg;

    localparam int XLEN_DEF      = 32;
    localparam int CTRL_BITS_DEF = 5;

    localparam logic [CTRL_BITS_DEF-1:0] ALUCTRL_ADD    = 5'd0;
    localparam logic [CTRL_BITS_DEF-1:0] ALUCTRL_SUB    = 5'd1;
    localparam logic [CTRL_BITS_DEF-1:0] ALUCTRL_AND    = 5'd2;
    localparam logic [CTRL_BITS_DEF-1:0] ALUCTRL_OR     = 5'd3;
    localparam logic [CTRL_BITS_DEF-1:0] ALUCTRL_XOR    = 5'd4;
    localparam logic [CTRL_BITS_DEF-1:0] ALUCTRL_SLL    = 5'd5;
    localparam logic [CTRL_BITS_DEF-1:0] ALUCTRL_SRL    = 5'd6;
    localparam logic [CTRL_BITS_DEF-1:0] ALUCTRL_SRA    = 5'd7;
    localparam logic [CTRL_BITS_DEF-1:0] ALUCTRL_SLT    = 5'd8;
    localparam logic [CTRL_BITS_DEF-1:0] ALUCTRL_SLTU   = 5'd9;
    localparam logic [CTRL_BITS_DEF-1:0] ALUCTRL_BEQ    = 5'd10;
    localparam logic [CTRL_BITS_DEF-1:0] ALUCTRL_BNE    = 5'd11;
    localparam logic [CTRL_BITS_DEF-1:0] ALUCTRL_BLT    = 5'd12;
    localparam logic [CTRL_BITS_DEF-1:0] ALUCTRL_BGE    = 5'd13;
    localparam logic [CTRL_BITS_DEF-1:0] ALUCTRL_BLTU   = 5'd14;
    localparam logic [CTRL_BITS_DEF-1:0] ALUCTRL_BGEU   = 5'd15;
    localparam logic [CTRL_BITS_DEF-1:0] ALUCTRL_MUL    = 5'd16;
    localparam logic [CTRL_BITS_DEF-1:0] ALUCTRL_MULH   = 5'd17;
    localparam logic [CTRL_BITS_DEF-1:0] ALUCTRL_MULHSU = 5'd18;
    localparam logic [CTRL_BITS_DEF-1:0] ALUCTRL_MULHU  = 5'd19;
    localparam logic [CTRL_BITS_DEF-1:0] ALUCTRL_DIV    = 5'd20;
    localparam logic [CTRL_BITS_DEF-1:0] ALUCTRL_DIVU   = 5'd21;
    localparam logic [CTRL_BITS_DEF-1:0] ALUCTRL_REM    = 5'd22;
    localparam logic [CTRL_BITS_DEF-1:0] ALUCTRL_REMU   = 5'd23;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_DONE
    } state_t;

    typedef enum logic [1:0] {
        MDU_LO,
        MDU_HI,
        MDU_QUO,
        MDU_REM
    } mdu_sel_t;

endpackage

// File: rtl/alu_mdu_if.sv
// Request/response bundle between an issuing stage and the ALU/MDU.
import alu_mdu_pkg::*;

interface alu_mdu_if #(
    parameter int XLEN      = XLEN_DEF,
    parameter int CTRL_BITS = CTRL_BITS_DEF
);
    logic                 req_valid;
    logic                 req_ready;
    logic [CTRL_BITS-1:0] op;
    logic [XLEN-1:0]      rs1;
    logic [XLEN-1:0]      rs2;
    logic [XLEN-1:0]      imm;
    logic                 alu_src;
    logic                 kill;
    logic                 resp_valid;
    logic                 resp_ready;
    logic [XLEN-1:0]      result;
    logic                 taken;
    logic                 busy;

    modport master (
        output req_valid, op, rs1, rs2, imm, alu_src, kill, resp_ready,
        input  req_ready, resp_valid, result, taken, busy
    );

    modport slave (
        input  req_valid, op, rs1, rs2, imm, alu_src, kill, resp_ready,
        output req_ready, resp_valid, result, taken, busy
    );
endinterface

// File: rtl/alu_mdu_seq.sv
// Iterative shift-add multiplier and restoring divider, one bit per cycle.
// Works on magnitudes; signs and divide-by-zero are fixed up on the outputs.
import alu_mdu_pkg::*;

module alu_mdu_seq #(
    parameter int XLEN = XLEN_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic              is_div,
    input  logic              a_signed,
    input  logic              b_signed,
    input  logic [XLEN-1:0]   a,
    input  logic [XLEN-1:0]   b,
    output logic              done,
    output logic [2*XLEN-1:0] product,
    output logic [XLEN-1:0]   quotient,
    output logic [XLEN-1:0]   remainder
);
    localparam int CW = $clog2(XLEN);

    logic            active_q;
    logic [CW-1:0]   cnt_q;
    logic [XLEN-1:0] hi_q;
    logic [XLEN-1:0] lo_q;
    logic [XLEN-1:0] opnd_q;
    logic [XLEN-1:0] a_q;
    logic            div_q;
    logic            neg_q;
    logic            neg_rem_q;
    logic            zero_q;

    logic            a_neg;
    logic            b_neg;
    logic [XLEN-1:0] a_mag;
    logic [XLEN-1:0] b_mag;
    logic [XLEN:0]   mul_sum;
    logic [XLEN:0]   rem_sh;
    logic [XLEN:0]   diff;
    logic            fits;
    logic [XLEN-1:0] hi_d;
    logic [XLEN-1:0] lo_d;
    logic [2*XLEN-1:0] prod_mag;

    assign a_neg = a_signed & a[XLEN-1];
    assign b_neg = b_signed & b[XLEN-1];
    assign a_mag = a_neg ? -a : a;
    assign b_mag = b_neg ? -b : b;

    // hi/lo hold accumulator/multiplier or partial remainder/quotient
    assign mul_sum = {1'b0, hi_q} + {1'b0, (lo_q[0] ? opnd_q : '0)};
    assign rem_sh  = {hi_q, lo_q[XLEN-1]};
    assign diff    = rem_sh - {1'b0, opnd_q};
    assign fits    = ~diff[XLEN];

    always_comb begin
        hi_d = mul_sum[XLEN:1];
        lo_d = {mul_sum[0], lo_q[XLEN-1:1]};
        if (div_q) begin
            hi_d = fits ? diff[XLEN-1:0] : rem_sh[XLEN-1:0];
            lo_d = {lo_q[XLEN-2:0], fits};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            active_q  <= 1'b0;
            cnt_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            opnd_q    <= '0;
            a_q       <= '0;
            div_q     <= 1'b0;
            neg_q     <= 1'b0;
            neg_rem_q <= 1'b0;
            zero_q    <= 1'b0;
        end else if (abort) begin
            active_q <= 1'b0;
            cnt_q    <= '0;
        end else if (start) begin
            active_q  <= 1'b1;
            cnt_q     <= '0;
            hi_q      <= '0;
            lo_q      <= a_mag;
            opnd_q    <= b_mag;
            a_q       <= a;
            div_q     <= is_div;
            neg_q     <= a_neg ^ b_neg;
            neg_rem_q <= a_neg;
            zero_q    <= is_div && (b == '0);
        end else if (active_q) begin
            hi_q  <= hi_d;
            lo_q  <= lo_d;
            cnt_q <= cnt_q + CW'(1);
            if (done) begin
                active_q <= 1'b0;
            end
        end
    end

    assign done      = active_q && (cnt_q == CW'(XLEN - 1));
    assign prod_mag  = {hi_q, lo_q};
    assign product   = neg_q ? -prod_mag : prod_mag;
    assign quotient  = zero_q ? '1 : (neg_q ? -lo_q : lo_q);
    assign remainder = zero_q ? a_q : (neg_rem_q ? -hi_q : hi_q);

endmodule

// File: rtl/alu_mdu.sv
// Integer ALU with single-cycle datapath plus an iterative M-extension unit.
// One request in flight; response held until the consumer accepts it.
import alu_mdu_pkg::*;

module alu_mdu #(
    parameter int XLEN      = XLEN_DEF,
    parameter int CTRL_BITS = CTRL_BITS_DEF
) (
    input logic       clk,
    input logic       rst_n,
    alu_mdu_if.slave  bus
);
    localparam int SHW = $clog2(XLEN);

    state_t   state_q;
    state_t   state_d;
    logic     accept;

    logic [XLEN-1:0] op2;
    logic [SHW-1:0]  shamt;
    logic            eq;
    logic            lt_s;
    logic            lt_u;

    logic [XLEN-1:0] alu_res;
    logic            alu_taken;
    logic            mdu_op;
    logic            is_div;
    logic            a_signed;
    logic            b_signed;
    mdu_sel_t        sel;

    logic [XLEN-1:0] result_q;
    logic            taken_q;
    logic            mdu_q;
    mdu_sel_t        sel_q;

    logic              seq_done;
    logic [2*XLEN-1:0] product;
    logic [XLEN-1:0]   quotient;
    logic [XLEN-1:0]   remainder;
    logic [XLEN-1:0]   mdu_res;

    assign op2   = bus.alu_src ? bus.imm : bus.rs2;
    assign shamt = op2[SHW-1:0];
    assign eq    = bus.rs1 == op2;
    assign lt_s  = $signed(bus.rs1) < $signed(op2);
    assign lt_u  = bus.rs1 < op2;

    always_comb begin
        alu_res   = '0;
        alu_taken = 1'b0;
        mdu_op    = 1'b0;
        is_div    = 1'b0;
        a_signed  = 1'b0;
        b_signed  = 1'b0;
        sel       = MDU_LO;
        case (bus.op)
            ALUCTRL_ADD:  alu_res = bus.rs1 + op2;
            ALUCTRL_SUB:  alu_res = bus.rs1 - op2;
            ALUCTRL_AND:  alu_res = bus.rs1 & op2;
            ALUCTRL_OR:   alu_res = bus.rs1 | op2;
            ALUCTRL_XOR:  alu_res = bus.rs1 ^ op2;
            ALUCTRL_SLL:  alu_res = bus.rs1 << shamt;
            ALUCTRL_SRL:  alu_res = bus.rs1 >> shamt;
            ALUCTRL_SRA:  alu_res = $unsigned($signed(bus.rs1) >>> shamt);
            ALUCTRL_SLT:  alu_res = {{(XLEN-1){1'b0}}, lt_s};
            ALUCTRL_SLTU: alu_res = {{(XLEN-1){1'b0}}, lt_u};
            ALUCTRL_BEQ:  alu_taken = eq;
            ALUCTRL_BNE:  alu_taken = ~eq;
            ALUCTRL_BLT:  alu_taken = lt_s;
            ALUCTRL_BGE:  alu_taken = ~lt_s;
            ALUCTRL_BLTU: alu_taken = lt_u;
            ALUCTRL_BGEU: alu_taken = ~lt_u;
            ALUCTRL_MUL: begin
                mdu_op = 1'b1;
            end
            ALUCTRL_MULH: begin
                mdu_op   = 1'b1;
                a_signed = 1'b1;
                b_signed = 1'b1;
                sel      = MDU_HI;
            end
            ALUCTRL_MULHSU: begin
                mdu_op   = 1'b1;
                a_signed = 1'b1;
                sel      = MDU_HI;
            end
            ALUCTRL_MULHU: begin
                mdu_op = 1'b1;
                sel    = MDU_HI;
            end
            ALUCTRL_DIV: begin
                mdu_op   = 1'b1;
                is_div   = 1'b1;
                a_signed = 1'b1;
                b_signed = 1'b1;
                sel      = MDU_QUO;
            end
            ALUCTRL_DIVU: begin
                mdu_op = 1'b1;
                is_div = 1'b1;
                sel    = MDU_QUO;
            end
            ALUCTRL_REM: begin
                mdu_op   = 1'b1;
                is_div   = 1'b1;
                a_signed = 1'b1;
                b_signed = 1'b1;
                sel      = MDU_REM;
            end
            ALUCTRL_REMU: begin
                mdu_op = 1'b1;
                is_div = 1'b1;
                sel    = MDU_REM;
            end
            default: ;
        endcase
    end

    // kill outranks both a new request and the response handshake
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        if (bus.kill) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.req_valid) begin
                        accept  = 1'b1;
                        state_d = mdu_op ? S_CALC : S_DONE;
                    end
                end
                S_CALC: begin
                    if (seq_done) begin
                        state_d = S_DONE;
                    end
                end
                S_DONE: begin
                    if (bus.resp_ready) begin
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            result_q <= '0;
            taken_q  <= 1'b0;
            mdu_q    <= 1'b0;
            sel_q    <= MDU_LO;
        end else if (accept) begin
            result_q <= alu_res;
            taken_q  <= alu_taken;
            mdu_q    <= mdu_op;
            sel_q    <= sel;
        end
    end

    alu_mdu_seq #(
        .XLEN (XLEN)
    ) u_seq (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (accept && mdu_op),
        .abort     (bus.kill),
        .is_div    (is_div),
        .a_signed  (a_signed),
        .b_signed  (b_signed),
        .a         (bus.rs1),
        .b         (op2),
        .done      (seq_done),
        .product   (product),
        .quotient  (quotient),
        .remainder (remainder)
    );

    always_comb begin
        mdu_res = product[XLEN-1:0];
        case (sel_q)
            MDU_HI:  mdu_res = product[2*XLEN-1:XLEN];
            MDU_QUO: mdu_res = quotient;
            MDU_REM: mdu_res = remainder;
            default: mdu_res = product[XLEN-1:0];
        endcase
    end

    assign bus.req_ready  = state_q == S_IDLE;
    assign bus.resp_valid = state_q == S_DONE;
    assign bus.busy       = state_q == S_CALC;
    assign bus.taken      = taken_q;
    assign bus.result     = (state_q == S_DONE && mdu_q) ? mdu_res : result_q;

endmodule

// File: tb/tb_alu_mdu.sv
// Bench for alu_mdu: directed corner cases plus random ops against a
// plain-arithmetic reference model of the RISC-V integer/M semantics.
module tb_alu_mdu;
    import alu_mdu_pkg::*;

    localparam int XLEN = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_assert = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    alu_mdu_if #(.XLEN(XLEN), .CTRL_BITS(5)) bus ();

    alu_mdu #(.XLEN(XLEN), .CTRL_BITS(5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic is_mdu(input logic [4:0] op);
        return op inside {ALUCTRL_MUL, ALUCTRL_MULH, ALUCTRL_MULHSU,
                          ALUCTRL_MULHU, ALUCTRL_DIV, ALUCTRL_DIVU,
                          ALUCTRL_REM, ALUCTRL_REMU};
    endfunction

    // returns {taken, result}
    function automatic logic [32:0] model(input logic [4:0] op,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
        logic [31:0] r;
        logic        t;
        int          sa;
        int          sb;
        logic [4:0]  sh;
        longint      p;
        logic [63:0] u;
        logic        ovf;
        r   = '0;
        t   = 1'b0;
        sa  = $signed(a);
        sb  = $signed(b);
        sh  = b[4:0];
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (op)
            ALUCTRL_ADD:  r = a + b;
            ALUCTRL_SUB:  r = a - b;
            ALUCTRL_AND:  r = a & b;
            ALUCTRL_OR:   r = a | b;
            ALUCTRL_XOR:  r = a ^ b;
            ALUCTRL_SLL:  r = a << sh;
            ALUCTRL_SRL:  r = a >> sh;
            ALUCTRL_SRA:  r = 32'(sa >>> sh);
            ALUCTRL_SLT:  r = (sa < sb) ? 32'd1 : 32'd0;
            ALUCTRL_SLTU: r = (a < b) ? 32'd1 : 32'd0;
            ALUCTRL_BEQ:  t = a == b;
            ALUCTRL_BNE:  t = a != b;
            ALUCTRL_BLT:  t = sa < sb;
            ALUCTRL_BGE:  t = sa >= sb;
            ALUCTRL_BLTU: t = a < b;
            ALUCTRL_BGEU: t = a >= b;
            ALUCTRL_MUL: begin
                u = {32'd0, a} * {32'd0, b};
                r = u[31:0];
            end
            ALUCTRL_MULH: begin
                p = longint'(sa) * longint'(sb);
                r = p[63:32];
            end
            ALUCTRL_MULHSU: begin
                p = longint'(sa) * longint'({32'd0, b});
                r = p[63:32];
            end
            ALUCTRL_MULHU: begin
                u = {32'd0, a} * {32'd0, b};
                r = u[63:32];
            end
            ALUCTRL_DIV: begin
                if (b == 0)   r = '1;
                else if (ovf) r = a;
                else          r = 32'(sa / sb);
            end
            ALUCTRL_DIVU: r = (b == 0) ? '1 : a / b;
            ALUCTRL_REM: begin
                if (b == 0)   r = a;
                else if (ovf) r = '0;
                else          r = 32'(sa % sb);
            end
            ALUCTRL_REMU: r = (b == 0) ? a : a % b;
            default: ;
        endcase
        return {t, r};
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'h0000_0001;
            4:       return 32'h7FFF_FFFF;
            5:       return 32'($urandom_range(0, 40));
            default: return $urandom;
        endcase
    endfunction

    task automatic scramble();
        bus.op      = 5'($urandom);
        bus.rs1     = $urandom;
        bus.rs2     = $urandom;
        bus.imm     = $urandom;
        bus.alu_src = 1'($urandom);
    endtask

    task automatic drive(input logic [4:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] imm,
                         input logic src);
        bus.op        = op;
        bus.rs1       = a;
        bus.rs2       = b;
        bus.imm       = imm;
        bus.alu_src   = src;
        bus.req_valid = 1'b1;
    endtask

    task automatic run_op(input string tag, input logic [4:0] op,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] imm, input logic src);
        logic [32:0] exp;
        int          exp_lat;
        int          lat;
        int          nbusy;
        exp     = model(op, a, src ? imm : b);
        exp_lat = is_mdu(op) ? XLEN + 1 : 1;
        check({tag, " req_ready"}, 64'(bus.req_ready), 64'd1);
        drive(op, a, b, imm, src);
        @(negedge clk);
        bus.req_valid = 1'b0;
        scramble();
        lat   = 1;
        nbusy = 0;
        while (bus.resp_valid !== 1'b1 && lat < 100) begin
            if (bus.busy === 1'b1) nbusy++;
            @(negedge clk);
            lat++;
        end
        check({tag, " latency"}, 64'(lat), 64'(exp_lat));
        check({tag, " busy_cycles"}, 64'(nbusy), 64'(exp_lat - 1));
        check({tag, " result"}, 64'(bus.result), 64'(exp[31:0]));
        check({tag, " taken"}, 64'(bus.taken), 64'(exp[32]));
        bus.resp_ready = 1'b1;
        @(negedge clk);
        bus.resp_ready = 1'b0;
        check({tag, " resp_cleared"}, 64'(bus.resp_valid), 64'd0);
    endtask

    task automatic check_silent(input string tag, input int cycles);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (bus.resp_valid !== 1'b0) seen = 1'b1;
        end
        check(tag, 64'(seen), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [31:0] held;
        logic [32:0] exp;
        int          waited;

        bus.req_valid  = 1'b0;
        bus.op         = '0;
        bus.rs1        = '0;
        bus.rs2        = '0;
        bus.imm        = '0;
        bus.alu_src    = 1'b0;
        bus.kill       = 1'b0;
        bus.resp_ready = 1'b0;

        repeat (3) @(negedge clk);
        check("rst resp_valid", 64'(bus.resp_valid), 64'd0);
        check("rst result", 64'(bus.result), 64'd0);
        check("rst taken", 64'(bus.taken), 64'd0);
        check("rst busy", 64'(bus.busy), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst req_ready", 64'(bus.req_ready), 64'd1);

        run_op("add_wrap", ALUCTRL_ADD, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0);
        run_op("blt", ALUCTRL_BLT, 32'hFFFF_FFFE, 32'd1, 32'd0, 1'b0);
        run_op("bltu", ALUCTRL_BLTU, 32'hFFFF_FFFE, 32'd1, 32'd0, 1'b0);
        run_op("mulh_min", ALUCTRL_MULH, 32'h8000_0000, 32'h8000_0000,
               32'd0, 1'b0);
        run_op("div_zero", ALUCTRL_DIV, 32'd7, 32'd0, 32'd0, 1'b0);
        run_op("rem_zero", ALUCTRL_REM, 32'd7, 32'd0, 32'd0, 1'b0);
        run_op("div_ovf", ALUCTRL_DIV, 32'h8000_0000, 32'hFFFF_FFFF,
               32'd0, 1'b0);
        run_op("rem_ovf", ALUCTRL_REM, 32'h8000_0000, 32'hFFFF_FFFF,
               32'd0, 1'b0);
        run_op("divu", ALUCTRL_DIVU, 32'hFFFF_FFF9, 32'd2, 32'd0, 1'b0);
        run_op("rem_neg", ALUCTRL_REM, 32'hFFFF_FFF9, 32'd2, 32'd0, 1'b0);
        run_op("add_imm", ALUCTRL_ADD, 32'd10, 32'd99, 32'hFFFF_FFFB, 1'b1);
        run_op("sra_imm", ALUCTRL_SRA, 32'h8000_0000, 32'd0, 32'h24, 1'b1);
        run_op("sll_mask", ALUCTRL_SLL, 32'h0000_0003, 32'h21, 32'd0, 1'b0);
        run_op("mulhsu", ALUCTRL_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
               32'd0, 1'b0);
        run_op("undef", 5'd27, 32'h1234_5678, 32'h1234_5678, 32'd0, 1'b0);

        // kill partway through a divide
        drive(ALUCTRL_DIVU, 32'hDEAD_BEEF, 32'd3, 32'd0, 1'b0);
        @(negedge clk);
        bus.req_valid = 1'b0;
        scramble();
        repeat (9) @(negedge clk);
        check("kill busy_before", 64'(bus.busy), 64'd1);
        bus.kill = 1'b1;
        @(negedge clk);
        bus.kill = 1'b0;
        check("kill resp_valid", 64'(bus.resp_valid), 64'd0);
        check("kill req_ready", 64'(bus.req_ready), 64'd1);
        check("kill busy", 64'(bus.busy), 64'd0);
        check_silent("kill no_resp", 40);
        run_op("sub_after_kill", ALUCTRL_SUB, 32'd5, 32'd7, 32'd0, 1'b0);

        // kill wins over a request in the same cycle
        drive(ALUCTRL_ADD, 32'd1, 32'd2, 32'd0, 1'b0);
        bus.kill = 1'b1;
        @(negedge clk);
        bus.kill      = 1'b0;
        bus.req_valid = 1'b0;
        check("kill_req resp_valid", 64'(bus.resp_valid), 64'd0);
        check("kill_req req_ready", 64'(bus.req_ready), 64'd1);

        // kill while the response is pending
        drive(ALUCTRL_XOR, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'd0, 1'b0);
        @(negedge clk);
        bus.req_valid = 1'b0;
        check("kill_done pre", 64'(bus.resp_valid), 64'd1);
        bus.kill = 1'b1;
        @(negedge clk);
        bus.kill = 1'b0;
        check("kill_done resp_valid", 64'(bus.resp_valid), 64'd0);
        check("kill_done req_ready", 64'(bus.req_ready), 64'd1);

        // response stall: outputs hold while resp_ready is low
        exp = model(ALUCTRL_MUL, 32'h0001_2345, 32'h0006_789A);
        drive(ALUCTRL_MUL, 32'h0001_2345, 32'h0006_789A, 32'd0, 1'b0);
        @(negedge clk);
        bus.req_valid = 1'b0;
        scramble();
        waited = 0;
        while (bus.resp_valid !== 1'b1 && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        check("stall reached_done", 64'(bus.resp_valid), 64'd1);
        held = exp[31:0];
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall result", 64'(bus.result), 64'(held));
            check("stall req_ready", 64'(bus.req_ready), 64'd0);
            check("stall resp_valid", 64'(bus.resp_valid), 64'd1);
        end
        bus.resp_ready = 1'b1;
        @(negedge clk);
        bus.resp_ready = 1'b0;
        check("stall release", 64'(bus.req_ready), 64'd1);

        // reset during CALC
        drive(ALUCTRL_MULH, 32'h8000_0000, 32'h7FFF_FFFF, 32'd0, 1'b0);
        @(negedge clk);
        bus.req_valid = 1'b0;
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("rst_calc resp_valid", 64'(bus.resp_valid), 64'd0);
        check("rst_calc result", 64'(bus.result), 64'd0);
        check("rst_calc taken", 64'(bus.taken), 64'd0);
        check("rst_calc busy", 64'(bus.busy), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_calc req_ready", 64'(bus.req_ready), 64'd1);
        check_silent("rst_calc no_resp", 40);

        // reset during DONE of a taken branch
        drive(ALUCTRL_BGEU, 32'd9, 32'd3, 32'd0, 1'b0);
        @(negedge clk);
        bus.req_valid = 1'b0;
        check("rst_done pre_taken", 64'(bus.taken), 64'd1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("rst_done taken", 64'(bus.taken), 64'd0);
        check("rst_done resp_valid", 64'(bus.resp_valid), 64'd0);

        for (int i = 0; i < 80; i++) begin
            run_op("rnd", 5'($urandom_range(0, 31)), pick(), pick(), pick(),
                   1'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
